// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor.
// BTB geometry, counter encoding, and entry layout.
package branch_target_predictor_pkg;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 32 - IDX_W - 2;

  localparam logic [6:0] B_TYPE = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_t             ctr;
  } btb_entry_t;

  // Saturating step of the 2-bit direction counter
  function automatic ctr_t ctr_step(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    unique case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_target_predictor_btb_storage.sv
// Direct-mapped BTB entry array.
// Lookup and update-side read ports are combinational; writes land on the edge.
module branch_target_predictor_btb_storage
  import branch_target_predictor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] upd_idx,
  output btb_entry_t       upd_entry,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem_q [ENTRIES];
  btb_entry_t mem_d [ENTRIES];

  assign rd_entry  = mem_q[rd_idx];
  assign upd_entry = mem_q[upd_idx];

  // Next array contents: single entry overwritten when enabled
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_idx] = wr_entry;
    end
  end

  // Entry registers; reset clears every entry and beats any write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage branch prediction with EX-stage resolution.
// Holds hit/saturation, mispredict/redirect and the perf counters.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        EX_valid,
  input  logic [6:0]  EX_op,
  input  logic [31:0] EX_pc,
  input  logic [31:0] EX_target,
  input  logic        actual_taken,
  input  logic        EX_pred_taken,
  input  logic [31:0] EX_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       if_entry;
  btb_entry_t       ex_entry;
  btb_entry_t       wr_entry;
  logic             if_hit;
  logic             ex_hit;
  logic             upd;
  logic             we;
  logic [31:0]      branch_cnt_q;
  logic [31:0]      branch_cnt_d;
  logic [31:0]      mispred_cnt_q;
  logic [31:0]      mispred_cnt_d;
  logic             unused_pc_lsbs;

  assign if_idx = IF_pc[IDX_W+1:2];
  assign if_tag = IF_pc[31:IDX_W+2];
  assign ex_idx = EX_pc[IDX_W+1:2];
  assign ex_tag = EX_pc[31:IDX_W+2];

  assign unused_pc_lsbs = ^{IF_pc[1:0], EX_pc[1:0]};

  branch_target_predictor_btb_storage u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_idx),
    .rd_entry  (if_entry),
    .upd_idx   (ex_idx),
    .upd_entry (ex_entry),
    .we        (we),
    .wr_idx    (ex_idx),
    .wr_entry  (wr_entry)
  );

  // IF lookup from pre-edge state
  always_comb begin
    if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    pred_taken  = if_hit && if_entry.ctr[1];
    pred_target = pred_taken ? if_entry.target : IF_pc + 32'd4;
  end

  // EX resolution: mispredict, redirect and the entry rewrite
  always_comb begin
    upd        = EX_valid && (EX_op == B_TYPE);
    ex_hit     = ex_entry.valid && (ex_entry.tag == ex_tag);
    mispredict = upd && ((actual_taken != EX_pred_taken) ||
                 (actual_taken && (EX_target != EX_pred_target)));
    redirect_pc = actual_taken ? EX_target : EX_pc + 32'd4;
    we       = upd && (ex_hit || actual_taken);
    wr_entry = ex_entry;
    if (ex_hit) begin
      wr_entry.ctr = ctr_step(ex_entry.ctr, actual_taken);
      if (actual_taken) begin
        wr_entry.target = EX_target;
      end
    end else begin
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = ex_tag;
      wr_entry.target = EX_target;
      wr_entry.ctr    = WT;
    end
  end

  // Perf counter next values, wrapping naturally at 32 bits
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
